// File: rtl/tile_ctrl_pkg.sv
// rtl/tile_ctrl_pkg.sv - shared types and constants for the tile reset/stall/irq controller
// Contents: sequencer state enum, hold length, interrupt-pending word layout and packer.
package tile_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } seq_state_t;

    // Cycles spent in HOLD after a reset or re-sequence request.
    localparam int HOLD_CYC = 2;

    localparam int IRQ_IP_W = 42;
    localparam logic [30:0] IRQ_BASE = 31'b1;

    // Pending-interrupt word: {IRQ_BASE, irqnum, 7'b0}.
    function automatic logic [IRQ_IP_W-1:0] irq_ip_pack(input logic [3:0] num);
        return {IRQ_BASE, num, 7'b0};
    endfunction

endpackage

// File: rtl/tile_ctrl_if.sv
// rtl/tile_ctrl_if.sv - interrupt buffer handshake bundle for tile_ctrl
// Signals:
//   irqload      load strobe from the interrupt source
//   irqnum[3:0]  interrupt number accompanying irqload
//   irq_ack      consumer accepts the pending entry
//   irq_req      an entry is pending
//   irq_ip[41:0] pending entry word
//   irq_drop_cnt dropped-interrupt count
// Modports: master = source/consumer side, slave = tile_ctrl side.
interface tile_ctrl_if;
    import tile_ctrl_pkg::*;

    logic                irqload;
    logic [3:0]          irqnum;
    logic                irq_ack;
    logic                irq_req;
    logic [IRQ_IP_W-1:0] irq_ip;
    logic [7:0]          irq_drop_cnt;

    modport master (
        output irqload,
        output irqnum,
        output irq_ack,
        input  irq_req,
        input  irq_ip,
        input  irq_drop_cnt
    );

    modport slave (
        input  irqload,
        input  irqnum,
        input  irq_ack,
        output irq_req,
        output irq_ip,
        output irq_drop_cnt
    );

endinterface

// File: rtl/tile_ctrl_dly.sv
// rtl/tile_ctrl_dly.sv - free-running register delay line, tap k = din delayed k+1 cycles
// Parameters: WIDTH (bits per tap), DEPTH (number of taps)
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (clears every tap)
//   din          line input
//   dout         all taps, dout[0] is one cycle late
module tile_ctrl_dly #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH-1:0]             din,
    output logic [DEPTH-1:0][WIDTH-1:0]  dout
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else begin
            dout[0] <= din;
            for (int k = 1; k < DEPTH; k++) begin
                dout[k] <= dout[k-1];
            end
        end
    end

endmodule

// File: rtl/tile_ctrl.sv
// rtl/tile_ctrl.sv - tile controller: staged core reset release, stall merge, miss delay line, single-entry irq buffer
// Optional feature macro: TILE_CTRL_IRQ_CNT_EN (dropped-interrupt counter; without it irq_drop_cnt is tied to 0)
// Ports:
//   clk          sole clock
//   rst_n        asynchronous active-low reset
//   soft_rst     synchronous request to re-run the reset sequence
//   core_stall   per-core resource stall vectors
//   miss_in      miss broadcast bus (NLANE lanes of MISSW bits)
//   core_rst     per-core active-high reset, released GROUP cores per cycle
//   rst_stage    global reset delayed 1..RSTSTG cycles
//   stall_any    registered OR of stalls from cores out of reset
//   miss_tap     miss_in delayed 1..TAPS cycles
//   irq_bus      interrupt buffer handshake (tile_ctrl_if.slave)
module tile_ctrl
    import tile_ctrl_pkg::*;
#(
    parameter int NCORE  = 36,
    parameter int GROUP  = 6,
    parameter int NSTALL = 12,
    parameter int NLANE  = 256,
    parameter int MISSW  = 36,
    parameter int TAPS   = 4,
    parameter int RSTSTG = 5
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  soft_rst,
    input  logic [NCORE-1:0][NSTALL-1:0]          core_stall,
    input  logic [NLANE-1:0][MISSW-1:0]           miss_in,
    output logic [NCORE-1:0]                      core_rst,
    output logic [RSTSTG-1:0]                     rst_stage,
    output logic [NSTALL-1:0]                     stall_any,
    output logic [TAPS-1:0][NLANE-1:0][MISSW-1:0] miss_tap,
    tile_ctrl_if.slave                            irq_bus
);

    localparam int NGRP = NCORE / GROUP;
    localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;

    seq_state_t          state;
    logic [1:0]          hold_cnt;
    logic [GW-1:0]       grp;
    logic                glob_rst;

    // Reset sequencer. glob_rst is kept as its own flop so it is exactly
    // "state is HOLD" without decoding the state vector downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_HOLD;
            hold_cnt <= '0;
            grp      <= '0;
            core_rst <= '1;
            glob_rst <= 1'b1;
        end else if (soft_rst) begin
            state    <= ST_HOLD;
            hold_cnt <= '0;
            grp      <= '0;
            core_rst <= '1;
            glob_rst <= 1'b1;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (hold_cnt == 2'(HOLD_CYC - 1)) begin
                        state    <= ST_RELEASE;
                        glob_rst <= 1'b0;
                        grp      <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 2'd1;
                    end
                end
                ST_RELEASE: begin
                    core_rst[int'(grp)*GROUP +: GROUP] <= '0;
                    if (grp == GW'(NGRP - 1)) begin
                        state <= ST_RUN;
                    end else begin
                        grp <= grp + 1'b1;
                    end
                end
                ST_RUN: begin
                end
                default: begin
                    state    <= ST_HOLD;
                    hold_cnt <= '0;
                    grp      <= '0;
                    core_rst <= '1;
                    glob_rst <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_stage <= '1;
        end else begin
            rst_stage[0] <= glob_rst;
            for (int k = 1; k < RSTSTG; k++) begin
                rst_stage[k] <= rst_stage[k-1];
            end
        end
    end

    // Stalls from cores still held in reset are meaningless and are masked.
    logic [NSTALL-1:0] stall_nxt;

    always_comb begin
        stall_nxt = '0;
        for (int i = 0; i < NCORE; i++) begin
            if (!core_rst[i]) begin
                stall_nxt = stall_nxt | core_stall[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_any <= '0;
        end else begin
            stall_any <= stall_nxt;
        end
    end

    tile_ctrl_dly #(
        .WIDTH (NLANE * MISSW),
        .DEPTH (TAPS)
    ) u_miss_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (miss_in),
        .dout  (miss_tap)
    );

    // Single-entry interrupt buffer. A load landing on a pending entry that
    // is being acked in the same cycle replaces it, so irq_req never blips.
    logic                irq_req_q;
    logic [IRQ_IP_W-1:0] irq_ip_q;
    logic                ld_ok;

    assign ld_ok = irq_bus.irqload && !glob_rst;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_req_q <= 1'b0;
            irq_ip_q  <= '0;
        end else if (irq_req_q && irq_bus.irq_ack) begin
            if (ld_ok) begin
                irq_ip_q <= irq_ip_pack(irq_bus.irqnum);
            end else begin
                irq_req_q <= 1'b0;
            end
        end else if (!irq_req_q && ld_ok) begin
            irq_req_q <= 1'b1;
            irq_ip_q  <= irq_ip_pack(irq_bus.irqnum);
        end
    end

    assign irq_bus.irq_req = irq_req_q;
    assign irq_bus.irq_ip  = irq_ip_q;

`ifdef TILE_CTRL_IRQ_CNT_EN
    logic [7:0] drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (irq_req_q && ld_ok && !irq_bus.irq_ack && drop_cnt != 8'hff) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign irq_bus.irq_drop_cnt = drop_cnt;
`else
    assign irq_bus.irq_drop_cnt = 8'd0;
`endif

endmodule

// File: doc/tile_ctrl.md
TILE_CTRL -- requirements
Module: tile_ctrl

Interface
REQ-001 SHALL have parameter NCORE, default 36: number of cores in the tile.
REQ-002 SHALL have parameter GROUP, default 6: cores released from reset per cycle; NCORE multiple of GROUP.
REQ-003 SHALL have parameter NSTALL, default 12: per-core resource-stall vector width.
REQ-004 SHALL have parameters NLANE, default 256, and MISSW, default 36: miss bus lanes and lane width.
REQ-005 SHALL have parameter TAPS, default 4, range 1..8: miss delay-line depth.
REQ-006 SHALL have parameter RSTSTG, default 5: global reset shadow-stage count.
REQ-007 clk  in  1  sole clock, all state on rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 soft_rst  in  1  synchronous re-sequence request.
REQ-010 core_stall  in  NCORE x NSTALL  per-core resource stalls.
REQ-011 miss_in  in  NLANE x MISSW  miss broadcast bus.
REQ-012 irqload  in  1  interrupt load strobe; irqnum  in  4  interrupt number.
REQ-013 irq_ack  in  1  consumer accepts pending interrupt.
REQ-014 core_rst  out  NCORE  per-core active-high reset.
REQ-015 rst_stage  out  RSTSTG  shifted copies of global reset, bit k = k+1 cycles late.
REQ-016 stall_any  out  NSTALL  registered OR of unmasked core stalls.
REQ-017 miss_tap  out  TAPS x NLANE x MISSW  tap k = miss_in delayed k+1 cycles.
REQ-018 irq_req  out  1; irq_ip  out  42  {31'b1, irqnum, 7'b0} of pending entry.
REQ-019 irq_drop_cnt  out  8  dropped-interrupt count.

Function
REQ-020 Sequencer SHALL have states HOLD, RELEASE, RUN.
REQ-021 HOLD SHALL last exactly 2 cycles after rst_n rises or soft_rst samples 1, then enter RELEASE.
REQ-022 RELEASE SHALL clear core_rst for group g (cores g*GROUP..g*GROUP+GROUP-1) on its g-th cycle; after group NCORE/GROUP-1 enter RUN.
REQ-023 Global reset SHALL be 1 in HOLD, 0 otherwise; rst_stage SHALL be its shift register.
REQ-024 soft_rst in any state SHALL force HOLD next cycle with all core_rst=1; soft_rst held keeps HOLD.
REQ-025 stall_any SHALL be OR over cores i with core_rst[i]=0 of core_stall[i], one-cycle latency.
REQ-026 miss_tap SHALL be a TAPS-deep register chain, 1 cycle per tap, no enable.
REQ-027 Interrupt buffer SHALL be single entry; irqload with no entry pending loads it, irq_req=1 next cycle.
REQ-028 irq_ack with irq_req=1 SHALL empty entry; simultaneous irqload SHALL reload entry, irq_req staying 1.
REQ-029 irqload while pending without irq_ack SHALL keep old entry and increment irq_drop_cnt, saturating at 255.
REQ-030 irqload SHALL be ignored while global reset is 1.

Reset
REQ-031 rst_n low SHALL immediately force HOLD, core_rst all 1, rst_stage all 1, stall_any 0, miss_tap 0, irq_req 0, irq_ip 0, irq_drop_cnt 0.
REQ-032 Reset mid-RELEASE SHALL reassert all core_rst; sequence restarts from group 0.

Configuration
REQ-033 With TILE_CTRL_IRQ_CNT_EN defined, REQ-029 counter SHALL be implemented; without it irq_drop_cnt SHALL be constant 0 and no counter flops exist.

Structure
REQ-034 Package tile_ctrl_pkg SHALL hold state enum, IRQ_IP_W=42, IRQ_BASE constant 31'b1.
REQ-035 Delay line SHALL be sub-module tile_ctrl_dly (width, depth parameters); rest flat.

Verification
REQ-036 Defaults, rst_n rises at cycle 0 -> HOLD cycles 1-2, group 0 released cycle 3, group 5 cycle 8, RUN cycle 9, rst_stage[4] falls cycle 7.
REQ-037 soft_rst pulse in RUN -> all 36 core_rst=1 next cycle, full 2+6 release repeats.
REQ-038 core_stall[3]=12'h004 while core 3 in reset -> stall_any=0; after release -> 12'h004 one cycle later.
REQ-039 miss_in lane 0 = 36'h1 for one cycle -> appears on tap 0..3 on cycles +1..+4, then 0.
REQ-040 irqnum=5 load, then 300 irqloads without ack -> irq_ip={31'b1,4'd5,7'b0}, irq_drop_cnt=255 (0 without macro); ack with irqload irqnum=9 -> irq_ip updates, irq_req stays 1.
